conv_result_fifo: RTL and testbench

//  Output stage downstream of the convolution core. Buffers the result samples Z[n] it produces.
//  The MCU drains them through the IPM-style bus (conf_dbus/read/write/data_in/data_out).

---
 rtl/conv_result_fifo.sv | 185 ++++++++++++++++++
 tb/tb_conv_result_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_fifo.sv
// conv_result_fifo: result-sample buffer between the convolution core and the MCU bus.
// Core side is a valid/ready push port with an end-of-stream marker; host side is a
// command/strobe bus with POP, STATUS, THRESH and CLEAR commands. Raises a level
// interrupt on end of stream or when occupancy reaches a programmable threshold.
// Optional feature macro: CONV_RESULT_FIFO_SAT16_EN (saturate samples to signed 16-bit).
module conv_result_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CONF_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  en_s,
    input  logic [DATA_WIDTH-1:0] z_data,
    input  logic                  z_valid,
    input  logic                  z_last,
    output logic                  z_ready,
    input  logic [CONF_WIDTH-1:0] conf_dbus,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  int_req,
    output logic [ADDR_WIDTH:0]   fifo_count
);

    localparam logic [CONF_WIDTH-1:0] CMD_POP    = CONF_WIDTH'(5'h04);
    localparam logic [CONF_WIDTH-1:0] CMD_STATUS = CONF_WIDTH'(5'h05);
    localparam logic [CONF_WIDTH-1:0] CMD_THRESH = CONF_WIDTH'(5'h06);
    localparam logic [CONF_WIDTH-1:0] CMD_CLEAR  = CONF_WIDTH'(5'h07);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   thresh_q, thresh_d;
    logic                  stall_q, stall_d;
    logic                  done_q, done_d;
    logic                  unf_q, unf_d;
    logic                  sat_q, sat_d;
    logic                  int_req_q, int_req_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic                  full, empty;
    logic                  cmd_pop, cmd_thr, cmd_clr;
    logic                  push, pop;
    logic                  clip;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] status_word;
    logic [ADDR_WIDTH:0]   thresh_in;
    logic                  unused_data_in;

    assign unused_data_in = ^data_in[DATA_WIDTH-1:ADDR_WIDTH+1];

    // Command decode and handshake; z_ready is forced low while reset is asserted.
    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        cmd_pop = en_s & read & (conf_dbus == CMD_POP);
        cmd_thr = en_s & write & (conf_dbus == CMD_THRESH);
        cmd_clr = en_s & write & (conf_dbus == CMD_CLEAR);
        z_ready = en_s & ~rst_a & ~full & ~(write & (conf_dbus == CMD_CLEAR));
        push    = z_valid & z_ready;
        pop     = cmd_pop & ~empty;
    end

`ifdef CONV_RESULT_FIFO_SAT16_EN
    // Clip to signed 16-bit: upper bits [W-1:15] must all match the sign.
    always_comb begin
        clip      = ~(&z_data[DATA_WIDTH-1:15]) & (|z_data[DATA_WIDTH-1:15]);
        push_data = z_data;
        if (clip) begin
            push_data = z_data[DATA_WIDTH-1] ? {{(DATA_WIDTH-16){1'b1}}, 16'h8000}
                                             : {{(DATA_WIDTH-16){1'b0}}, 16'h7FFF};
        end
    end
`else
    // Samples are stored verbatim.
    always_comb begin
        clip      = 1'b0;
        push_data = z_data;
    end
`endif

    // Status word assembly for the STATUS command.
    always_comb begin
        status_word                 = '0;
        status_word[DATA_WIDTH-1]   = stall_q;
        status_word[DATA_WIDTH-2]   = done_q;
        status_word[DATA_WIDTH-3]   = full;
        status_word[DATA_WIDTH-4]   = empty;
        status_word[DATA_WIDTH-5]   = unf_q;
        status_word[DATA_WIDTH-6]   = sat_q;
        status_word[ADDR_WIDTH:0]   = count_q;
    end

    // Next-state for pointers, occupancy, flags, threshold, read data and interrupt.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        thresh_d   = thresh_q;
        data_out_d = data_out_q;
        thresh_in  = data_in[ADDR_WIDTH:0];

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        stall_d = stall_q | (en_s & z_valid & full);
        done_d  = done_q | (push & z_last);
        unf_d   = unf_q | (cmd_pop & empty);
        sat_d   = sat_q | (push & clip);

        if (cmd_thr) thresh_d = (thresh_in > DEPTH_C) ? DEPTH_C : thresh_in;

        if (en_s & read) begin
            case (conf_dbus)
                CMD_POP:    data_out_d = empty ? '0 : mem_q[rd_ptr_q];
                CMD_STATUS: data_out_d = status_word;
                default:    data_out_d = '0;
            endcase
        end

        // CLEAR wins over any push/pop bookkeeping in the same cycle.
        if (cmd_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            stall_d  = 1'b0;
            done_d   = 1'b0;
            unf_d    = 1'b0;
            sat_d    = 1'b0;
        end

        int_req_d = done_d | ((thresh_d != '0) & (count_d >= thresh_d));
    end

    // Control/state registers; en_s low freezes everything.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            thresh_q   <= '0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            unf_q      <= 1'b0;
            sat_q      <= 1'b0;
            int_req_q  <= 1'b0;
            data_out_q <= '0;
        end else if (en_s) begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            thresh_q   <= thresh_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            unf_q      <= unf_d;
            sat_q      <= sat_d;
            int_req_q  <= int_req_d;
            data_out_q <= data_out_d;
        end
    end

    // Sample storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign data_out   = data_out_q;
    assign int_req    = int_req_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_conv_result_fifo.sv
// Directed bench for conv_result_fifo with a queue scoreboard of expected samples.
module tb_conv_result_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 64;
    localparam int AW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_a, en_s, z_valid, z_last, read, write;
    logic [DW-1:0] z_data, data_in;
    logic [CW-1:0] conf_dbus;
    logic          z_ready, int_req;
    logic [DW-1:0] data_out;
    logic [AW:0]   fifo_count;

    int            n_pass = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    logic [DW-1:0] last_pop = '0;
    logic [DW-1:0] st;

    conv_result_fifo dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s),
        .z_data(z_data), .z_valid(z_valid), .z_last(z_last), .z_ready(z_ready),
        .conf_dbus(conf_dbus), .read(read), .write(write), .data_in(data_in),
        .data_out(data_out), .int_req(int_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat_model(input logic [DW-1:0] d);
`ifdef CONV_RESULT_FIFO_SAT16_EN
        if ($signed(d) > 32767) return 32'h0000_7FFF;
        if ($signed(d) < -32768) return 32'hFFFF_8000;
`endif
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic last);
        z_data = d; z_valid = 1'b1; z_last = last;
        #1;
        check("z_ready", {31'd0, z_ready}, {31'd0, (m_count < DEPTH)});
        tick();
        if (m_count < DEPTH) begin
            exp_q.push_back(sat_model(d));
            m_count++;
        end
        z_valid = 1'b0; z_last = 1'b0;
        check("fifo_count", {25'd0, fifo_count}, m_count);
    endtask

    task automatic pop();
        conf_dbus = 5'h04; read = 1'b1;
        tick();
        read = 1'b0;
        if (m_count > 0) begin
            last_pop = exp_q.pop_front();
            m_count--;
            check("pop_data", data_out, last_pop);
        end else begin
            last_pop = '0;
            check("underflow_data", data_out, '0);
        end
        check("fifo_count", {25'd0, fifo_count}, m_count);
    endtask

    task automatic cmd_write(input logic [CW-1:0] c, input logic [DW-1:0] d);
        conf_dbus = c; data_in = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic read_status(output logic [DW-1:0] s);
        conf_dbus = 5'h05; read = 1'b1;
        tick();
        read = 1'b0;
        s = data_out;
    endtask

    task automatic clear();
        cmd_write(5'h07, '0);
        exp_q.delete();
        m_count = 0;
    endtask

    initial begin
        rst_a = 1'b1; en_s = 1'b0; z_valid = 1'b0; z_last = 1'b0; read = 1'b0;
        write = 1'b0; z_data = '0; data_in = '0; conf_dbus = '0;
        #1;
        check("rst_z_ready", {31'd0, z_ready}, 0);
        check("rst_int_req", {31'd0, int_req}, 0);
        check("rst_data_out", data_out, 0);
        check("rst_count", {25'd0, fifo_count}, 0);
        tick(); tick();
        rst_a = 1'b0; en_s = 1'b1;
        #1;
        check("post_rst_z_ready", {31'd0, z_ready}, 1);
        read_status(st);
        check("status_reset", st, 32'h1000_0000);

        // Fill to full, then drain in order, then underflow.
        for (int i = 1; i <= DEPTH; i++) push(i, 1'b0);
        #1;
        check("full_z_ready", {31'd0, z_ready}, 0);
        read_status(st);
        check("status_full", st, 32'h2000_0040);
        for (int i = 1; i <= DEPTH; i++) pop();
        pop();
        read_status(st);
        check("status_underflow", st, 32'h1800_0000);

        // Steady occupancy of 10 while streaming 200 samples through the wrap.
        clear();
        for (int i = 0; i < 10; i++) push(1000 + i, 1'b0);
        for (int i = 0; i < 200; i++) begin
            z_data = 5000 + i; z_valid = 1'b1; conf_dbus = 5'h04; read = 1'b1;
            #1;
            check("stream_z_ready", {31'd0, z_ready}, 1);
            tick();
            z_valid = 1'b0; read = 1'b0;
            exp_q.push_back(sat_model(5000 + i));
            check("stream_data", data_out, exp_q.pop_front());
            check("stream_count", {25'd0, fifo_count}, 10);
        end
        for (int i = 0; i < 10; i++) pop();

        // Threshold interrupt at 8.
        clear();
        cmd_write(5'h06, 8);
        for (int i = 0; i < 8; i++) begin
            push(200 + i, 1'b0);
            check("thr8_int", {31'd0, int_req}, {31'd0, (i == 7)});
        end
        pop();
        check("thr8_int_after_pop", {31'd0, int_req}, 0);

        // Threshold 100 clamps to 64: interrupt only on the 64th entry.
        clear();
        cmd_write(5'h06, 100);
        for (int i = 0; i < DEPTH; i++) begin
            push(300 + i, 1'b0);
            check("thr64_int", {31'd0, int_req}, {31'd0, (i == DEPTH - 1)});
        end

        // Stall while full, then done on the final push.
        z_data = 32'hDEAD; z_valid = 1'b1;
        #1;
        check("stall_z_ready", {31'd0, z_ready}, 0);
        tick();
        z_valid = 1'b0;
        read_status(st);
        check("status_stall", {28'd0, st[31:28]}, 4'b1010);
        cmd_write(5'h06, 0);
        check("thr0_int", {31'd0, int_req}, 0);
        pop();
        push(32'h77, 1'b1);
        check("done_int", {31'd0, int_req}, 1);
        read_status(st);
        check("status_done", {28'd0, st[31:28]}, 4'b1110);
        cmd_write(5'h06, 4);
        clear();
        check("clear_int", {31'd0, int_req}, 0);
        read_status(st);
        check("status_clear", st, 32'h1000_0000);
        for (int i = 0; i < 4; i++) begin
            push(400 + i, 1'b0);
            check("thr_kept_int", {31'd0, int_req}, {31'd0, (i == 3)});
        end

        // Saturation (or verbatim storage without the feature).
        clear();
        push(32'h0001_2345, 1'b0);
        push(32'hFFFF_0000, 1'b0);
        push(32'h0000_1234, 1'b0);
        for (int i = 0; i < 3; i++) pop();
        read_status(st);
`ifdef CONV_RESULT_FIFO_SAT16_EN
        check("status_sat", {31'd0, st[26]}, 1);
`else
        check("status_sat", {31'd0, st[26]}, 0);
`endif

        // en_s low freezes pops, pushes and read data.
        push(32'h55, 1'b0);
        pop();
        push(32'h66, 1'b0);
        push(32'h67, 1'b0);
        en_s = 1'b0; conf_dbus = 5'h04; read = 1'b1; z_data = 32'h99; z_valid = 1'b1;
        #1;
        check("frozen_z_ready", {31'd0, z_ready}, 0);
        tick();
        read = 1'b0; z_valid = 1'b0;
        check("frozen_data_out", data_out, last_pop);
        check("frozen_count", {25'd0, fifo_count}, 2);
        en_s = 1'b1;

        // Reset asserted mid-push with interrupt and read data live.
        push(32'h68, 1'b0);
        push(32'h69, 1'b0);
        check("pre_rst_int", {31'd0, int_req}, 1);
        z_data = 32'h6A; z_valid = 1'b1;
        rst_a = 1'b1;
        #1;
        check("midrst_z_ready", {31'd0, z_ready}, 0);
        check("midrst_int_req", {31'd0, int_req}, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_count", {25'd0, fifo_count}, 0);
        z_valid = 1'b0;
        tick();
        rst_a = 1'b0;
        exp_q.delete();
        m_count = 0;
        #1;
        check("post_midrst_z_ready", {31'd0, z_ready}, 1);
        push(32'h1234, 1'b0);
        pop();
        pop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
